pipeline_control: RTL
=====================

# pipeline_control

Central sequencer for the five-stage pipeline. Each cycle it arbitrates four requests: the memory-busy freeze, the ID-stage Stall, Jump and Branch. From them it drives the PC mux select, the PC and IF/ID write enables, the IF/ID flush, the ID/EX bubble insert and the EX/MEM and MEM/WB write enables. It guards against a hung data memory with a timeout that halts the pipeline, and it keeps saturating stall and flush counters for performance debug.

## Interface
- MEM_TIMEOUT, default 255: number of consecutive MemBusy cycles that trips BusError. Legal range 2..65535.
- CNT_WIDTH, default 16: width of the StallCycles and FlushCount counters.
- Clk  input  1  pipeline clock; all state updates on the rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Stall  input  1  hazard stall request from the ID stage (load-use or branch-compare hazard).
- Branch  input  1  branch taken, from the ID stage.
- Jump  input  1  jump, from the ID stage.
- MemBusy  input  1  data memory not ready this cycle.
- PCWrite  output  1  PC register load enable.
- PCSel  output  2  PC mux select: 00 = PC+4, 01 = branch target, 10 = jump target; 11 is never driven.
- IFIDWrite  output  1  IF/ID register load enable.
- IFIDFlush  output  1  IF/ID register clear (loads a nop).
- IDEXBubble  output  1  zeroes the control fields loaded into ID/EX.
- EXMEMWrite  output  1  EX/MEM register load enable.
- MEMWBWrite  output  1  MEM/WB register load enable.
- BusError  output  1  sticky memory-timeout flag.
- StallCycles  output  CNT_WIDTH  saturating count of stall and freeze cycles.
- FlushCount  output  CNT_WIDTH  saturating count of redirects.

## Operation
- States: RUN, REDIRECT, MEMWAIT, HALT. Reset state is RUN.
- Outputs are combinational (Mealy) from the current state and inputs. The state register, the wait counter and the statistics counters are the only registers.
- Decode in RUN and REDIRECT is by priority, highest first:
  - MemBusy=1, freeze: PCWrite, IFIDWrite, EXMEMWrite and MEMWBWrite are 0; IFIDFlush and IDEXBubble are 0; PCSel is 00. Next state MEMWAIT, wait counter = 1, StallCycles +1.
  - Stall=1 (RUN only): PCWrite=0, IFIDWrite=0, IDEXBubble=1, EXMEMWrite=1, MEMWBWrite=1. State stays RUN, StallCycles +1.
  - Jump=1 (RUN only): PCSel=10, PCWrite=1, IFIDFlush=1, other enables 1. Next state REDIRECT, FlushCount +1.
  - Branch=1 (RUN only): same as Jump but PCSel=01. Jump wins when both are asserted.
  - Otherwise, normal: PCWrite, IFIDWrite, EXMEMWrite and MEMWBWrite are 1; IFIDFlush and IDEXBubble are 0; PCSel is 00. Next state RUN.
- REDIRECT lasts exactly one cycle. Stall, Jump and Branch are ignored in it because they belong to the squashed slot. Decode is MemBusy, else normal; next state RUN, or MEMWAIT if MemBusy.
- MEMWAIT:
  - With MemBusy=1: freeze outputs, wait counter +1, StallCycles +1.
  - When the wait counter equals MEM_TIMEOUT at a rising edge with MemBusy still 1: next state HALT and BusError set.
  - With MemBusy=0: decode exactly as RUN, including Stall, Jump and Branch, and move to the resulting next state. The wait counter clears.
- HALT: all enables 0, IFIDFlush=0, IDEXBubble=0, PCSel=00, and the counters are frozen. It is left only by reset. BusError stays 1.
- Counters saturate at all-ones and never wrap.

## Timing
- Zero-cycle decode: enables are valid in the same cycle as the request, and the stage registers sample them on the same rising edge.
- A redirect costs one cycle: the target is fetched on the cycle after the edge on which Branch or Jump was seen.
- With ResetN low, asynchronously and independent of Clk:
  - state RUN; wait counter, StallCycles, FlushCount and BusError all 0;
  - outputs forced to PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, EXMEMWrite=0, MEMWBWrite=0, PCSel=00.
- After ResetN rises: normal RUN decode from the first cycle.
- Reset mid-MEMWAIT or mid-HALT returns to RUN with all counts cleared.
- MemBusy for exactly MEM_TIMEOUT-1 consecutive cycles must not trip BusError. MemBusy for MEM_TIMEOUT consecutive cycles must.

## Test plan
- Reset, then 10 idle cycles -> all four write enables 1 every cycle, PCSel=00, StallCycles=0, FlushCount=0.
- Stall high for 3 cycles -> PCWrite=0, IFIDWrite=0 and IDEXBubble=1 on those cycles only; StallCycles=3.
- Branch and Jump high for 2 cycles -> cycle 1: PCSel=10, IFIDFlush=1. Cycle 2 (REDIRECT): request ignored, PCSel=00, IFIDFlush=0. FlushCount=1.
- MEM_TIMEOUT=4: MemBusy for 3 cycles then low -> all enables 0 for 3 cycles, resume with BusError=0. MemBusy for 4 cycles -> HALT, BusError=1, all enables 0 until ResetN pulses low.
- MemBusy and Stall together, then MemBusy drops with Stall still high -> freeze first, then IDEXBubble=1 on the release cycle.
- Preload StallCycles near all-ones with CNT_WIDTH=4 and stall 20 cycles -> StallCycles holds at 15.

Source files
------------

// File: rtl/pipeline_control.sv
// Central sequencer for the five-stage pipeline: arbitrates freeze, stall and
// redirect requests into stage enables, with a memory-timeout halt and debug counters.
module pipeline_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 Stall,
  input  logic                 Branch,
  input  logic                 Jump,
  input  logic                 MemBusy,
  output logic                 PCWrite,
  output logic [1:0]           PCSel,
  output logic                 IFIDWrite,
  output logic                 IFIDFlush,
  output logic                 IDEXBubble,
  output logic                 EXMEMWrite,
  output logic                 MEMWBWrite,
  output logic                 BusError,
  output logic [CNT_WIDTH-1:0] StallCycles,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  typedef enum logic [1:0] {RUN, REDIRECT, MEMWAIT, HALT} state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [15:0]            wait_q, wait_d, busy_run;
  logic [CNT_WIDTH-1:0]   stall_q, flush_q;
  logic                   berr_q;
  logic                   stall_inc, flush_inc, berr_set;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    PCWrite    = 1'b1;
    PCSel      = 2'b00;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    EXMEMWrite = 1'b1;
    MEMWBWrite = 1'b1;
    state_d    = RUN;
    wait_d     = '0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    berr_set   = 1'b0;
    // Busy cycles seen so far in this run of MemBusy, including the current one.
    busy_run   = (state_q == MEMWAIT) ? wait_q + 16'd1 : 16'd1;

    if (state_q == HALT) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      MEMWBWrite = 1'b0;
      state_d    = HALT;
    end else if (MemBusy) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      MEMWBWrite = 1'b0;
      stall_inc  = 1'b1;
      if (busy_run == TIMEOUT) begin
        state_d  = HALT;
        berr_set = 1'b1;
      end else begin
        state_d  = MEMWAIT;
        wait_d   = busy_run;
      end
    end else if (state_q != REDIRECT) begin
      // Requests in REDIRECT belong to the squashed slot and are dropped.
      if (Stall) begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
        stall_inc  = 1'b1;
      end else if (Jump || Branch) begin
        PCSel     = Jump ? 2'b10 : 2'b01;
        IFIDFlush = 1'b1;
        flush_inc = 1'b1;
        state_d   = REDIRECT;
      end
    end

    if (!ResetN) begin
      PCWrite    = 1'b0;
      PCSel      = 2'b00;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
      EXMEMWrite = 1'b0;
      MEMWBWrite = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (stall_inc) stall_q <= sat_inc(stall_q);
      if (flush_inc) flush_q <= sat_inc(flush_q);
      if (berr_set)  berr_q  <= 1'b1;
    end
  end

  assign BusError    = berr_q;
  assign StallCycles = stall_q;
  assign FlushCount  = flush_q;

endmodule
